// File: rtl/adder_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the adder-sharing arbiter.
package adder_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned ID_W      = $clog2(N_REQ_DEF);

    // Upper bound on requesters the pick function can scan.
    localparam int unsigned MAX_REQ = 32;

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_t;

    // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... mod n. Returns 0 if none is set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if (!found && (k < n) && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or after the pointer.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IdW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [IdW-1:0]   o_grant_idx,
    output logic             o_any
);

    int unsigned w_pick;
    logic        w_unused_pick;

    assign w_pick        = rr_pick(MAX_REQ'(i_req), 32'(i_ptr), N_REQ);
    assign o_grant_idx   = w_pick[IdW-1:0];
    // Index is always below N_REQ, so the upper bits carry nothing.
    assign w_unused_pick = ^w_pick[31:IdW];
    assign o_any         = |i_req;
    assign o_grant_oh    = o_any ? (N_REQ'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/adder_share_arbiter.sv
// One WIDTH-bit adder shared by N_REQ requesters; round-robin grant, one-entry result register.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH:0]           res_sum,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     busy
);

    localparam int unsigned   IdW    = $clog2(N_REQ);
    localparam logic [IdW-1:0] LastId = IdW'(N_REQ - 1);

    out_state_t       r_state;
    out_state_t       w_state_next;
    logic [WIDTH:0]   r_sum;
    logic [IdW-1:0]   r_id;
    logic [IdW-1:0]   r_ptr;
    logic [IdW-1:0]   w_ptr_next;
    logic [N_REQ-1:0] w_grant_oh;
    logic [IdW-1:0]   w_grant_idx;
    logic             w_any;
    logic             w_drain;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IdW   (IdW)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_drain  = (r_state == FULL) && res_ready;
    // Reset gates acceptance so no requester sees ready while rst_n is low.
    assign w_accept = rst_n && ((r_state == EMPTY) || w_drain) && w_any;
    assign req_ready = w_grant_oh & {N_REQ{w_accept}};

    // Operand mux: AND-OR select of the granted pair using the one-hot grant.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    // Explicit wrap keeps the pointer legal when N_REQ is not a power of two.
    assign w_ptr_next = (w_grant_idx == LastId) ? '0 : w_grant_idx + 1'b1;

    // Output FSM next state: fill on accept, empty on drain without refill.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_next = FULL;
            FULL:    if (w_drain && !w_accept) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    // State, result register and round-robin pointer; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sum <= w_sum;
                r_id  <= w_grant_idx;
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign res_valid = (r_state == FULL);
    assign res_sum   = r_sum;
    assign res_id    = r_id;
    assign busy      = res_valid | w_any;

endmodule
